// File: rtl/softmax_stream_ctrl.sv
// Row-streaming sequencer for the softmax core: issues source reads under an
// in-flight row limit, writes results to the destination buffer, reports done.
module softmax_stream_ctrl #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 16,
   parameter int LEN_W        = 10,
   parameter int ROWS_W       = 8,
   parameter int MAX_INFLIGHT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_start,
   input  logic [LEN_W-1:0]  cfg_row_len,
   input  logic [ROWS_W-1:0] cfg_num_rows,
   input  logic [ADDR_W-1:0] cfg_src_base,
   input  logic [ADDR_W-1:0] cfg_dst_base,
   output logic              busy,
   output logic              done,
   output logic              err_overflow,
   output logic              src_rd_en,
   output logic [ADDR_W-1:0] src_rd_addr,
   input  logic [DATA_W-1:0] src_rd_data,
   output logic              sm_a_tvalid,
   output logic [DATA_W-1:0] sm_a_tdata,
   output logic              sm_a_tlast,
   input  logic              sm_result_tvalid,
   input  logic [DATA_W-1:0] sm_result_tdata,
   output logic              dst_wr_en,
   output logic [ADDR_W-1:0] dst_wr_addr,
   output logic [DATA_W-1:0] dst_wr_data
);

   localparam int CNT_W = LEN_W + ROWS_W;
   localparam int INF_W = $clog2(MAX_INFLIGHT + 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ISSUE = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   logic [2:0]        state_r;
   logic [2:0]        state_s;
   logic [LEN_W-1:0]  row_len_r;
   logic [ROWS_W-1:0] num_rows_r;
   logic [CNT_W-1:0]  total_r;
   logic [ADDR_W-1:0] src_ptr_r;
   logic [ADDR_W-1:0] dst_base_r;
   logic [LEN_W-1:0]  col_r;
   logic [ROWS_W-1:0] row_r;
   logic [INF_W-1:0]  inflight_r;
   logic [INF_W-1:0]  inflight_s;
   logic [LEN_W-1:0]  out_col_r;
   logic [CNT_W-1:0]  recv_r;
   logic [CNT_W-1:0]  recv_s;
   logic              err_r;
   logic              tvalid_r;
   logic              tlast_r;
   logic              busy_r;
   logic              done_r;

   logic rd_s;
   logic row_end_s;
   logic last_row_s;
   logic accept_s;
   logic out_row_end_s;
   logic start_ok_s;

   assign rd_s          = (state_r == ST_ISSUE);
   assign row_end_s     = rd_s && (col_r == row_len_r - LEN_W'(1'b1));
   assign last_row_s    = (row_r == num_rows_r - ROWS_W'(1'b1));
   assign accept_s      = sm_result_tvalid && busy_r && (recv_r < total_r);
   assign out_row_end_s = accept_s && (out_col_r == row_len_r - LEN_W'(1'b1));
   assign recv_s        = recv_r + CNT_W'(accept_s);
   assign start_ok_s    = cfg_start && (state_r == ST_IDLE);

   // In-flight row count: a row enters on its last read, leaves on its last result
   always_comb begin
      inflight_s = inflight_r;
      case ({row_end_s, out_row_end_s})
         2'b10:   inflight_s = inflight_r + INF_W'(1'b1);
         2'b01:   inflight_s = inflight_r - INF_W'(1'b1);
         default: inflight_s = inflight_r;
      endcase
   end

   // Sequencer next-state decision
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cfg_start) begin
               if ((cfg_row_len == LEN_W'(1'b0)) || (cfg_num_rows == ROWS_W'(1'b0))) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_ISSUE;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (row_end_s) begin
               if (last_row_s) begin
                  state_s = ST_DRAIN;
               end else if (inflight_s == INF_W'(MAX_INFLIGHT)) begin
                  state_s = ST_WAIT;
               end else begin
                  state_s = ST_ISSUE;
               end
            end else begin
               state_s = ST_ISSUE;
            end
         end
         ST_WAIT: begin
            if (inflight_r < INF_W'(MAX_INFLIGHT)) begin
               state_s = ST_ISSUE;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_DRAIN: begin
            if ((recv_s == total_r) && !tvalid_r) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         ST_DONE:  state_s = ST_IDLE;
         default:  state_s = ST_IDLE;
      endcase
   end

   // Control state, counters, config latch and issue pipeline
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         tvalid_r   <= 1'b0;
         tlast_r    <= 1'b0;
         row_len_r  <= '0;
         num_rows_r <= '0;
         total_r    <= '0;
         src_ptr_r  <= '0;
         dst_base_r <= '0;
         col_r      <= '0;
         row_r      <= '0;
         inflight_r <= '0;
         out_col_r  <= '0;
         recv_r     <= '0;
         err_r      <= 1'b0;
      end else begin
         state_r  <= state_s;
         busy_r   <= (state_s != ST_IDLE);
         done_r   <= (state_s == ST_DONE);
         tvalid_r <= rd_s;
         tlast_r  <= row_end_s;
         if (start_ok_s) begin
            row_len_r  <= cfg_row_len;
            num_rows_r <= cfg_num_rows;
            total_r    <= CNT_W'(cfg_row_len) * CNT_W'(cfg_num_rows);
            src_ptr_r  <= cfg_src_base;
            dst_base_r <= cfg_dst_base;
            col_r      <= '0;
            row_r      <= '0;
            inflight_r <= '0;
            out_col_r  <= '0;
            recv_r     <= '0;
            err_r      <= 1'b0;
         end else begin
            if (rd_s) begin
               src_ptr_r <= src_ptr_r + ADDR_W'(1'b1);
               if (row_end_s) begin
                  col_r <= '0;
                  row_r <= row_r + ROWS_W'(1'b1);
               end else begin
                  col_r <= col_r + LEN_W'(1'b1);
               end
            end
            inflight_r <= inflight_s;
            recv_r     <= recv_s;
            if (accept_s) begin
               out_col_r <= out_row_end_s ? LEN_W'(1'b0) : out_col_r + LEN_W'(1'b1);
            end
            // A result nobody is waiting for is dropped and remembered
            if (sm_result_tvalid && !accept_s) begin
               err_r <= 1'b1;
            end
         end
      end
   end

   assign busy         = busy_r;
   assign done         = done_r;
   assign err_overflow = err_r;
   assign src_rd_en    = rd_s;
   assign src_rd_addr  = src_ptr_r;
   assign sm_a_tvalid  = tvalid_r;
   assign sm_a_tlast   = tlast_r;
   assign sm_a_tdata   = tvalid_r ? src_rd_data : {DATA_W{1'b0}};
   assign dst_wr_en    = accept_s;
   assign dst_wr_addr  = accept_s ? (dst_base_r + ADDR_W'(recv_r)) : {ADDR_W{1'b0}};
   assign dst_wr_data  = accept_s ? sm_result_tdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_softmax_stream_ctrl.sv
// Self-checking bench: a transaction-level model of the row sequencer is
// compared against the DUT every cycle, plus hand-derived timing pins.
module tb_softmax_stream_ctrl;

   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 16;
   localparam int LEN_W   = 10;
   localparam int ROWS_W  = 8;
   localparam int MAX_INF = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cfg_start = 1'b0;
   logic [LEN_W-1:0]  cfg_row_len = '0;
   logic [ROWS_W-1:0] cfg_num_rows = '0;
   logic [ADDR_W-1:0] cfg_src_base = '0;
   logic [ADDR_W-1:0] cfg_dst_base = '0;
   logic              busy, done, err_overflow, src_rd_en, sm_a_tvalid, sm_a_tlast, dst_wr_en;
   logic [ADDR_W-1:0] src_rd_addr, dst_wr_addr;
   logic [DATA_W-1:0] src_rd_data = '0;
   logic [DATA_W-1:0] sm_a_tdata, dst_wr_data;
   logic              sm_result_tvalid = 1'b0;
   logic [DATA_W-1:0] sm_result_tdata = '0;

   always #5 clk = ~clk;

   softmax_stream_ctrl #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .ROWS_W(ROWS_W), .MAX_INFLIGHT(MAX_INF)
   ) dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_row_len(cfg_row_len),
      .cfg_num_rows(cfg_num_rows), .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base),
      .busy(busy), .done(done), .err_overflow(err_overflow), .src_rd_en(src_rd_en),
      .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data), .sm_a_tvalid(sm_a_tvalid),
      .sm_a_tdata(sm_a_tdata), .sm_a_tlast(sm_a_tlast), .sm_result_tvalid(sm_result_tvalid),
      .sm_result_tdata(sm_result_tdata), .dst_wr_en(dst_wr_en), .dst_wr_addr(dst_wr_addr),
      .dst_wr_data(dst_wr_data)
   );

   typedef struct {
      int          due;
      logic [31:0] d;
   } res_t;

   int total_n = 0;
   int bad_n   = 0;
   int cyc     = 0;

   logic              start_req = 1'b0;
   logic              spur_req  = 1'b0;
   logic              rst_lvl   = 1'b1;
   logic [LEN_W-1:0]  req_len   = '0;
   logic [ROWS_W-1:0] req_rows  = '0;
   logic [15:0]       req_src   = '0;
   logic [15:0]       req_dst   = '0;
   int                lat       = 4;

   logic        pend_rd   = 1'b0;
   logic [15:0] pend_addr = '0;
   res_t        resq[$];

   // model state
   int          m_phase = 0;
   int          m_len = 0, m_rows = 0, m_total = 0;
   int          m_reads = 0, m_rows_read = 0, m_rows_done = 0, m_recv = 0;
   logic [15:0] m_src = '0, m_dst = '0, m_prev_addr = '0;
   logic        m_stalled = 1'b0, m_err = 1'b0, m_prev_rd = 1'b0, m_prev_last = 1'b0;

   // per-run observations of the DUT
   int          start_cyc = 0, done_cyc = -1, n_reads = 0, n_writes = 0, max_inf = 0;
   int          rd_cyc[$];
   logic [15:0] rd_addr[$];

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      return {a ^ 16'hC3A5, 16'h0000};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total_n++;
      if (act !== exp) begin
         bad_n++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic model_clear();
      m_phase = 0; m_reads = 0; m_rows_read = 0; m_rows_done = 0; m_recv = 0;
      m_stalled = 1'b0; m_err = 1'b0; m_prev_rd = 1'b0; m_prev_last = 1'b0;
   endtask

   task automatic step();
      logic        res_v, boundary, exp_rd, exp_acc, row_end_now, old_prev;
      logic [31:0] res_d;
      logic [15:0] r16, a;
      int          inf, slen, old_phase, obs;
      @(posedge clk);
      #1;
      rst          = rst_lvl;
      cfg_start    = start_req;
      cfg_row_len  = req_len;
      cfg_num_rows = req_rows;
      cfg_src_base = req_src;
      cfg_dst_base = req_dst;
      src_rd_data  = pend_rd ? mem_word(pend_addr) : 32'($urandom);
      res_v = 1'b0;
      res_d = 32'($urandom);
      if (resq.size() > 0 && resq[0].due <= cyc) begin
         res_v = 1'b1;
         res_d = resq[0].d;
         void'(resq.pop_front());
      end
      if (spur_req) res_v = 1'b1;
      sm_result_tvalid = res_v;
      sm_result_tdata  = res_d;
      @(negedge clk);
      if (rst) begin
         chk("rst_ctrl", {busy, done, err_overflow, src_rd_en, sm_a_tvalid, sm_a_tlast, dst_wr_en}, 64'd0);
         chk("rst_addr", {src_rd_addr, dst_wr_addr}, 64'd0);
         chk("rst_data", {sm_a_tdata, dst_wr_data}, 64'd0);
         model_clear();
         resq.delete();
         pend_rd = 1'b0;
      end else begin
         slen     = (m_len == 0) ? 1 : m_len;
         inf      = m_rows_read - m_rows_done;
         boundary = (m_phase == 1) && (m_reads > 0) && (m_reads < m_total) && (m_reads % slen == 0);
         exp_rd   = (m_phase == 1) && (m_reads < m_total) && !m_stalled && !(boundary && inf >= MAX_INF);
         exp_acc  = res_v && (m_phase != 0) && (m_recv < m_total);

         chk("busy", busy, m_phase != 0);
         chk("done", done, m_phase == 2);
         chk("err_overflow", err_overflow, m_err);
         chk("src_rd_en", src_rd_en, exp_rd);
         if (exp_rd) begin
            a = m_src + 16'(m_reads);
            chk("src_rd_addr", src_rd_addr, a);
         end
         chk("sm_a_tvalid", sm_a_tvalid, m_prev_rd);
         if (m_prev_rd) begin
            chk("sm_a_tlast", sm_a_tlast, m_prev_last);
            chk("sm_a_tdata", sm_a_tdata, mem_word(m_prev_addr));
         end
         chk("dst_wr_en", dst_wr_en, exp_acc);
         if (exp_acc) begin
            a = m_dst + 16'(m_recv);
            chk("dst_wr_addr", dst_wr_addr, a);
            chk("dst_wr_data", dst_wr_data, res_d);
         end

         // environment: source memory and a fixed-latency softmax core
         pend_rd   = src_rd_en;
         pend_addr = src_rd_addr;
         if (sm_a_tvalid) begin
            r16 = 16'($urandom);
            resq.push_back('{cyc + lat, {r16, 16'h0000}});
         end
         if (src_rd_en) begin
            n_reads++;
            rd_cyc.push_back(cyc);
            rd_addr.push_back(src_rd_addr);
         end
         if (dst_wr_en) n_writes++;
         if (done) done_cyc = cyc;
         if (m_len > 0) begin
            obs = n_reads / m_len - n_writes / m_len;
            if (obs > max_inf) max_inf = obs;
         end

         // advance the model by one cycle
         old_prev    = m_prev_rd;
         row_end_now = exp_rd && ((m_reads + 1) % slen == 0);
         if (exp_acc && ((m_recv + 1) % slen == 0)) m_rows_done++;
         if (exp_rd) begin
            m_prev_addr = m_src + 16'(m_reads);
            m_reads++;
            if (row_end_now) m_rows_read++;
         end
         m_prev_rd   = exp_rd;
         m_prev_last = row_end_now;
         if (res_v && !exp_acc) m_err = 1'b1;
         if (exp_acc) m_recv++;
         if (m_stalled) begin
            if (inf < MAX_INF) m_stalled = 1'b0;
         end else if (boundary && inf >= MAX_INF) begin
            m_stalled = 1'b1;
         end
         old_phase = m_phase;
         case (old_phase)
            0: if (cfg_start) begin
                  m_len = int'(req_len); m_rows = int'(req_rows); m_total = m_len * m_rows;
                  m_src = req_src; m_dst = req_dst;
                  m_reads = 0; m_rows_read = 0; m_rows_done = 0; m_recv = 0;
                  m_stalled = 1'b0; m_err = 1'b0;
                  m_phase = (m_total == 0) ? 2 : 1;
                  start_cyc = cyc;
               end
            1: if (m_reads == m_total && !exp_rd && !old_prev && m_recv == m_total) m_phase = 2;
            default: m_phase = 0;
         endcase
      end
      cyc++;
      start_req = 1'b0;
      spur_req  = 1'b0;
   endtask

   task automatic clear_stats();
      n_reads = 0; n_writes = 0; max_inf = 0; done_cyc = -1;
      rd_cyc.delete(); rd_addr.delete();
   endtask

   task automatic wait_idle();
      int n = 0;
      while (m_phase != 0 && n < 4000) begin
         step();
         n++;
      end
      if (m_phase != 0) chk("timeout", m_phase, 0);
      step();
      step();
   endtask

   task automatic launch(input int len, input int rows, input logic [15:0] src,
                         input logic [15:0] dst, input int l);
      req_len = LEN_W'(len); req_rows = ROWS_W'(rows);
      req_src = src; req_dst = dst; lat = l;
      clear_stats();
      start_req = 1'b1;
      step();
   endtask

   task automatic run_cfg(input int len, input int rows, input logic [15:0] src,
                          input logic [15:0] dst, input int l);
      launch(len, rows, src, dst, l);
      wait_idle();
   endtask

   initial begin
      logic [15:0] wexp[4];
      int          n;
      for (int i = 0; i < 3; i++) step();
      rst_lvl = 1'b0;
      step();
      step();

      // single 4-element row, latency 6
      run_cfg(4, 1, 16'h0010, 16'h0200, 6);
      chk("t1_reads", n_reads, 4);
      chk("t1_writes", n_writes, 4);
      chk("t1_first_rd", rd_cyc.size() > 0 ? rd_cyc[0] - start_cyc : -1, 1);
      for (int i = 0; i < 4; i++)
         if (i < rd_addr.size()) chk("t1_addr", rd_addr[i], 16'h0010 + 16'(i));
      chk("t1_done_at", done_cyc - start_cyc, 12);

      // credit stall: 3x5, latency 20
      run_cfg(3, 5, 16'h0100, 16'h0800, 20);
      chk("t2_reads", n_reads, 15);
      chk("t2_writes", n_writes, 15);
      chk("t2_row1_end", rd_cyc.size() > 5 ? rd_cyc[5] - start_cyc : -1, 6);
      chk("t2_resume", rd_cyc.size() > 6 ? rd_cyc[6] - start_cyc : -1, 26);
      chk("t2_max_inflight", max_inf <= MAX_INF, 1'b1);

      // row completion coincides with the next row's last read
      run_cfg(3, 5, 16'h0300, 16'h0900, 2);
      chk("t3_reads", n_reads, 15);
      chk("t3_contiguous", rd_cyc.size() == 15 ? rd_cyc[14] - rd_cyc[0] : -1, 14);

      // spurious result while idle, cleared by next start
      clear_stats();
      spur_req = 1'b1;
      step();
      step();
      chk("spur_err", err_overflow, 1'b1);
      chk("spur_no_write", n_writes, 0);
      run_cfg(2, 1, 16'h0400, 16'h0a00, 3);
      chk("spur_cleared", err_overflow, 1'b0);

      // degenerate configs
      run_cfg(0, 3, 16'h0500, 16'h0b00, 3);
      chk("t5_len0_done_at", done_cyc - start_cyc, 1);
      chk("t5_len0_reads", n_reads, 0);
      run_cfg(4, 0, 16'h0500, 16'h0b00, 3);
      chk("t5_rows0_reads", n_reads, 0);

      // start pulsed during a busy run is ignored
      launch(2, 2, 16'h0600, 16'h0c00, 5);
      for (int i = 0; i < 3; i++) step();
      req_len = LEN_W'(7);
      start_req = 1'b1;
      step();
      wait_idle();
      chk("t5_ignored_reads", n_reads, 4);

      // reset in the middle of row 2, then a clean 2x2 run
      launch(3, 3, 16'h0700, 16'h0d00, 10);
      n = 0;
      while (n_reads < 5 && n < 100) begin
         step();
         n++;
      end
      chk("t6_reached_row2", n_reads, 5);
      rst_lvl = 1'b1;
      step();
      step();
      rst_lvl = 1'b0;
      step();
      run_cfg(2, 2, 16'h0020, 16'h0e00, 4);
      chk("t6_reads", n_reads, 4);
      chk("t6_writes", n_writes, 4);

      // source pointer wrap
      run_cfg(4, 1, 16'hFFFE, 16'hFFFD, 5);
      wexp[0] = 16'hFFFE; wexp[1] = 16'hFFFF; wexp[2] = 16'h0000; wexp[3] = 16'h0001;
      chk("wrap_reads", n_reads, 4);
      for (int i = 0; i < 4; i++)
         if (i < rd_addr.size()) chk("wrap_addr", rd_addr[i], wexp[i]);

      // randomized configurations
      for (int r = 0; r < 8; r++) begin
         int len, rows;
         len  = int'($urandom_range(1, 5));
         rows = int'($urandom_range(1, 4));
         run_cfg(len, rows, 16'($urandom), 16'($urandom), int'($urandom_range(1, 12)));
         chk("rand_writes", n_writes, len * rows);
         chk("rand_max_inflight", max_inf <= MAX_INF, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end

endmodule
